// File: rtl/sqrt_share_arbiter.sv
// Round-robin share of one pipelined integer square root among NUM_REQ requesters.
// The latency is NUM_PIPELINE_STAGES. Per-requester credits gate req_ready, and a result sink must always accept.

module sqrt_int #(
    parameter int DATAWIDTH           = 8,
    parameter int NUM_PIPELINE_STAGES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [DATAWIDTH-1:0] i_rad,
    output logic                 o_valid,
    output logic [DATAWIDTH-1:0] o_root,
    output logic [DATAWIDTH-1:0] o_rem
);
    localparam int N  = DATAWIDTH / 2;
    localparam int R  = (NUM_PIPELINE_STAGES < N) ? NUM_PIPELINE_STAGES : N;
    localparam int E  = NUM_PIPELINE_STAGES - R;
    localparam int SW = DATAWIDTH + 2;

    // One restoring-sqrt digit per step; R of the N step outputs are registered, spread evenly.
    for (genvar s = 0; s < N; s++) begin : g_step
        localparam bit REG = (((s + 1) * R) / N) != ((s * R) / N);

        logic                 w_vld_in;
        logic [DATAWIDTH-1:0] w_rad_in;
        logic [DATAWIDTH-1:0] w_root_in;
        logic [SW-1:0]        w_rem_in;
        logic [SW-1:0]        w_shift;
        logic [SW-1:0]        w_trial;
        logic [SW-1:0]        w_rem_nxt;
        logic [DATAWIDTH-1:0] w_root_nxt;
        logic                 w_ge;
        logic                 w_out_vld;
        logic [DATAWIDTH-1:0] w_out_rad;
        logic [DATAWIDTH-1:0] w_out_root;
        logic [SW-1:0]        w_out_rem;
        logic                 w_unused_in;

        if (s == 0) begin : g_src
            assign w_vld_in  = i_valid;
            assign w_rad_in  = i_rad;
            assign w_root_in = '0;
            assign w_rem_in  = '0;
        end else begin : g_src
            assign w_vld_in  = g_step[s-1].w_out_vld;
            assign w_rad_in  = g_step[s-1].w_out_rad;
            assign w_root_in = g_step[s-1].w_out_root;
            assign w_rem_in  = g_step[s-1].w_out_rem;
        end

        assign w_shift     = {w_rem_in[SW-3:0], w_rad_in[DATAWIDTH-1-2*s -: 2]};
        assign w_trial     = {w_root_in, 2'b01};
        assign w_ge        = (w_shift >= w_trial);
        assign w_rem_nxt   = w_ge ? (w_shift - w_trial) : w_shift;
        assign w_root_nxt  = {w_root_in[DATAWIDTH-2:0], w_ge};
        assign w_unused_in = ^{w_rem_in[SW-1:SW-2], w_root_in[DATAWIDTH-1]};

        if (REG) begin : g_reg
            logic                 r_vld;
            logic [DATAWIDTH-1:0] r_rad;
            logic [DATAWIDTH-1:0] r_root;
            logic [SW-1:0]        r_rem;

            always_ff @(posedge i_clk) begin
                r_vld  <= i_rst ? 1'b0 : w_vld_in;
                r_rad  <= w_rad_in;
                r_root <= w_root_nxt;
                r_rem  <= w_rem_nxt;
            end

            assign w_out_vld  = r_vld;
            assign w_out_rad  = r_rad;
            assign w_out_root = r_root;
            assign w_out_rem  = r_rem;
        end else begin : g_wire
            assign w_out_vld  = w_vld_in;
            assign w_out_rad  = w_rad_in;
            assign w_out_root = w_root_nxt;
            assign w_out_rem  = w_rem_nxt;
        end
    end

    logic                 w_fin_vld;
    logic [DATAWIDTH-1:0] w_fin_root;
    logic [DATAWIDTH-1:0] w_fin_rem;
    logic                 w_unused_fin;

    assign w_fin_vld    = g_step[N-1].w_out_vld;
    assign w_fin_root   = g_step[N-1].w_out_root;
    assign w_fin_rem    = g_step[N-1].w_out_rem[DATAWIDTH-1:0];
    assign w_unused_fin = ^{g_step[N-1].w_out_rad, g_step[N-1].w_out_rem[SW-1:SW-2]};

    // Latency beyond one register per digit is padded at the output.
    if (E == 0) begin : g_noext
        assign o_valid = w_fin_vld;
        assign o_root  = w_fin_root;
        assign o_rem   = w_fin_rem;
    end else begin : g_ext
        logic                 r_vld  [E];
        logic [DATAWIDTH-1:0] r_root [E];
        logic [DATAWIDTH-1:0] r_rem  [E];

        always_ff @(posedge i_clk) begin
            r_vld[0]  <= i_rst ? 1'b0 : w_fin_vld;
            r_root[0] <= w_fin_root;
            r_rem[0]  <= w_fin_rem;
            for (int k = 1; k < E; k++) begin
                r_vld[k]  <= i_rst ? 1'b0 : r_vld[k-1];
                r_root[k] <= r_root[k-1];
                r_rem[k]  <= r_rem[k-1];
            end
        end

        assign o_valid = r_vld[E-1];
        assign o_root  = r_root[E-1];
        assign o_rem   = r_rem[E-1];
    end
endmodule

module sqrt_share_arbiter #(
    parameter int  DATAWIDTH           = 8,
    parameter int  NUM_REQ             = 4,
    parameter int  NUM_PIPELINE_STAGES = 3,
    parameter int  MAX_OUTSTANDING     = 2,
    localparam int IDW                 = $clog2(NUM_REQ),
    localparam int CW                  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_rad,
    output logic                           resp_valid,
    output logic [IDW-1:0]                 resp_id,
    output logic [DATAWIDTH-1:0]           resp_root,
    output logic [DATAWIDTH-1:0]           resp_rem,
    output logic                           busy
);
    localparam int LAT = NUM_PIPELINE_STAGES;

    logic [CW-1:0]        r_cnt     [NUM_REQ];
    logic [IDW-1:0]       r_ptr;
    logic                 r_idl_vld [LAT];
    logic [IDW-1:0]       r_idl_id  [LAT];

    logic [NUM_REQ-1:0]   w_elig;
    logic [NUM_REQ-1:0]   w_inc;
    logic [NUM_REQ-1:0]   w_dec;
    logic                 w_grant_vld;
    logic [IDW-1:0]       w_grant_id;
    logic [IDW-1:0]       w_idx;
    logic                 w_accept;
    logic [DATAWIDTH-1:0] w_rad_sel;
    logic                 w_sq_vld;
    logic [DATAWIDTH-1:0] w_sq_root;
    logic [DATAWIDTH-1:0] w_sq_rem;
    logic                 w_ret_vld;
    logic [IDW-1:0]       w_ret_id;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_valid[i] && (r_cnt[i] < CW'(MAX_OUTSTANDING));
        end
    end

    // Search starts one past the last winner so the last winner ranks lowest.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_grant_vld && w_elig[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx;
            end
        end
    end

    assign w_accept = w_grant_vld && !rst;

    always_comb begin
        req_ready = '0;
        w_rad_sel = '0;
        w_inc     = '0;
        w_dec     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (w_grant_id == IDW'(i));
            w_inc[i]     = w_accept && (w_grant_id == IDW'(i));
            w_dec[i]     = w_ret_vld && (w_ret_id == IDW'(i));
            if (w_grant_id == IDW'(i)) begin
                w_rad_sel = req_rad[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    sqrt_int #(
        .DATAWIDTH           (DATAWIDTH),
        .NUM_PIPELINE_STAGES (NUM_PIPELINE_STAGES)
    ) u_sqrt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (w_accept),
        .i_rad   (w_rad_sel),
        .o_valid (w_sq_vld),
        .o_root  (w_sq_root),
        .o_rem   (w_sq_rem)
    );

    // The requester tag travels beside the datapath, one slot per pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                r_idl_vld[k] <= 1'b0;
                r_idl_id[k]  <= '0;
            end
        end else begin
            r_idl_vld[0] <= w_accept;
            r_idl_id[0]  <= w_grant_id;
            for (int k = 1; k < LAT; k++) begin
                r_idl_vld[k] <= r_idl_vld[k-1];
                r_idl_id[k]  <= r_idl_id[k-1];
            end
        end
    end

    assign w_ret_vld = r_idl_vld[LAT-1];
    assign w_ret_id  = r_idl_id[LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IDW'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_grant_id;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + CW'(1);
            end else if (w_dec[i] && !w_inc[i]) begin
                r_cnt[i] <= r_cnt[i] - CW'(1);
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_cnt[i] != '0) begin
                busy = 1'b1;
            end
        end
    end

    assign resp_valid = w_sq_vld;
    assign resp_id    = w_ret_id;
    assign resp_root  = w_sq_root;
    assign resp_rem   = w_sq_rem;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_sq_vld == w_ret_vld);
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (r_cnt[i] <= CW'(MAX_OUTSTANDING));
                assert (!(w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)));
            end
        end
    end
`endif
endmodule
